// File: rtl/zuart_pkg.sv
// zuart_pkg: definitions shared across the ZUART path (baud generator, TX/RX shifters).
//   ZUART_DIV_W       - width of a per-bit divisor, in clock cycles
//   ZUART_OSR         - oversample ticks per bit
//   ZUART_DEFAULT_DIV - divisor after reset (50 MHz / 115200)
//   zuart_div_t       - divisor type
package zuart_pkg;

  localparam int unsigned ZUART_DIV_W       = 16;
  localparam int unsigned ZUART_OSR         = 16;
  localparam int unsigned ZUART_DEFAULT_DIV = 434;

  typedef logic [ZUART_DIV_W-1:0] zuart_div_t;

endpackage

// File: rtl/zuart_os_accum.sv
// zuart_os_accum: oversample tick accumulator.
// Adds OSR on each enabled cycle. When the sum reaches P, it subtracts P and
// strobes os_tick. This gives exactly OSR ticks per P cycles, evenly spread
// with no drift. Usable standalone by RX.
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   P       - effective cycles per bit (caller guarantees P >= OSR)
//   en      - run enable; low clears the accumulator and holds os_tick low
//   clr     - restart pulse; the accumulator restarts from zero on this edge
//             and no tick is issued
//   os_tick - registered one-cycle strobe
module zuart_os_accum
  import zuart_pkg::*;
#(
  parameter int unsigned DIV_W = ZUART_DIV_W,
  parameter int unsigned OSR   = ZUART_OSR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] P,
  input  logic             en,
  input  logic             clr,
  output logic             os_tick
);

  localparam logic [DIV_W:0] C_OSR = (DIV_W+1)'(OSR);

  logic [DIV_W:0] r_os_acc;
  logic           r_os_tick;

  logic [DIV_W:0] w_base;
  logic [DIV_W:0] w_sum;
  logic [DIV_W:0] w_p;
  logic           w_hit;
  logic [DIV_W:0] w_next;

  // The clr edge is counted as the first step from an empty accumulator,
  // which keeps os_tick phase-aligned with the restarted bit counter.
  assign w_base = clr ? '0 : r_os_acc;
  assign w_sum  = w_base + C_OSR;
  assign w_p    = {1'b0, P};
  assign w_hit  = (w_sum >= w_p);
  assign w_next = w_hit ? (w_sum - w_p) : w_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_os_acc  <= '0;
      r_os_tick <= 1'b0;
    end else if (!en) begin
      r_os_acc  <= '0;
      r_os_tick <= 1'b0;
    end else begin
      r_os_acc  <= w_next;
      r_os_tick <= w_hit && !clr;
    end
  end

  assign os_tick = r_os_tick;

endmodule

// File: rtl/zuart_baud_gen.sv
// zuart_baud_gen: runtime-programmable baud-rate generator.
// Optional feature macro: ZUART_BAUD_FRAC_EN (adds frac_i and a fractional
// divisor that stretches some bits to P+1 cycles).
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   en       - run enable; low holds counters at zero and strobes low
//   div_i    - requested cycles per bit
//   div_load - pulse: capture div_i into the shadow divisor
//   sync     - pulse: restart bit phase (RX start-bit edge)
//   frac_i   - fractional divisor in sixteenths (ZUART_BAUD_FRAC_EN only)
//   bit_tick - strobe at each bit boundary
//   mid_tick - strobe at the bit centre
//   os_tick  - OSR strobes per bit period
module zuart_baud_gen
  import zuart_pkg::*;
#(
  parameter int unsigned DIV_W       = ZUART_DIV_W,
  parameter int unsigned OSR         = ZUART_OSR,
  parameter int unsigned DEFAULT_DIV = ZUART_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load,
  input  logic             sync,
`ifdef ZUART_BAUD_FRAC_EN
  input  logic [3:0]       frac_i,
`endif
  output logic             bit_tick,
  output logic             mid_tick,
  output logic             os_tick
);

  localparam logic [DIV_W-1:0] C_OSR = DIV_W'(OSR);
  localparam logic [DIV_W-1:0] C_DEF = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] r_div_sh;
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_cnt;
  logic             r_bit_tick;
  logic             r_mid_tick;

  logic [DIV_W-1:0] w_p;
  logic             w_long;
  logic [DIV_W:0]   w_last;
  logic [DIV_W-1:0] w_mid;
  logic [DIV_W-1:0] w_base;
  logic             w_at_last;
  logic             w_at_mid;
  logic             w_wrap;

  // Divisors below OSR would leave no room for OSR oversample ticks per bit.
  assign w_p    = (r_div_q < C_OSR) ? C_OSR : r_div_q;
  assign w_last = {1'b0, w_p} - (DIV_W+1)'(1) + (DIV_W+1)'(w_long);
  assign w_mid  = (w_p >> 1) - DIV_W'(1);

  // A sync edge behaves like the first enabled edge after idle. The count
  // restarts from zero and this edge is the first counted cycle, so the bit
  // ends exactly Plen cycles later. Strobes are suppressed on this edge.
  assign w_base    = sync ? '0 : r_cnt;
  assign w_at_last = ({1'b0, w_base} == w_last);
  assign w_at_mid  = (w_base == w_mid);
  assign w_wrap    = en && !sync && w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_sh   <= C_DEF;
      r_div_q    <= C_DEF;
      r_cnt      <= '0;
      r_bit_tick <= 1'b0;
      r_mid_tick <= 1'b0;
    end else begin
      if (div_load) begin
        r_div_sh <= div_i;
      end
      // On a wrap that coincides with div_load, this takes the old shadow.
      if (!en || sync || w_wrap) begin
        r_div_q <= r_div_sh;
      end
      if (!en) begin
        r_cnt      <= '0;
        r_bit_tick <= 1'b0;
        r_mid_tick <= 1'b0;
      end else begin
        r_cnt      <= w_at_last ? '0 : (w_base + DIV_W'(1));
        r_bit_tick <= w_at_last && !sync;
        r_mid_tick <= w_at_mid && !sync;
      end
    end
  end

`ifdef ZUART_BAUD_FRAC_EN
  logic [3:0] r_frac_acc;
  logic       r_frac_long;

  assign w_long = r_frac_long;

  // The carry out of the sixteenths accumulator lengthens the next bit by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frac_acc  <= '0;
      r_frac_long <= 1'b0;
    end else if (!en || sync) begin
      r_frac_acc  <= '0;
      r_frac_long <= 1'b0;
    end else if (w_at_last) begin
      {r_frac_long, r_frac_acc} <= {1'b0, r_frac_acc} + {1'b0, frac_i};
    end
  end
`else
  assign w_long = 1'b0;
`endif

  zuart_os_accum #(
    .DIV_W (DIV_W),
    .OSR   (OSR)
  ) u_os_accum (
    .clk     (clk),
    .rst     (rst),
    .P       (w_p),
    .en      (en),
    .clr     (sync),
    .os_tick (os_tick)
  );

  assign bit_tick = r_bit_tick;
  assign mid_tick = r_mid_tick;

endmodule

// File: tb/tb_zuart_baud_gen.sv
// tb_zuart_baud_gen: directed bench for zuart_baud_gen with default parameters.
// Cycle k is the clock period after the k-th rising edge that samples en = 1.
// Inputs are driven on falling edges. Outputs are sampled on falling edges.
module tb_zuart_baud_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div_i;
  logic        div_load;
  logic        sync;
`ifdef ZUART_BAUD_FRAC_EN
  logic [3:0]  frac_i;
`endif
  logic        bit_tick;
  logic        mid_tick;
  logic        os_tick;

  int n_vec = 0;
  int n_err = 0;

  int q_bit[$];
  int q_mid[$];
  int q_os[$];

  zuart_baud_gen #(
    .DIV_W       (16),
    .OSR         (16),
    .DEFAULT_DIV (434)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_i    (div_i),
    .div_load (div_load),
    .sync     (sync),
`ifdef ZUART_BAUD_FRAC_EN
    .frac_i   (frac_i),
`endif
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .os_tick  (os_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Idle for two edges with en low, then raise en so the next edge is cycle 1.
  task automatic restart();
    div_load = 1'b0;
    sync     = 1'b0;
    en       = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
  endtask

  // While idle, load a divisor. With en low, the shadow is copied to the active divisor.
  task automatic set_div(input int v);
    en    = 1'b0;
    div_i = 16'(v);
    @(negedge clk);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Run n cycles and record the cycle number of every strobe. Pulses are
  // driven during the named cycle so the following edge samples them.
  task automatic run_cycles(input int n, input int load_at, input int sync_at, input int drop_at);
    q_bit.delete();
    q_mid.delete();
    q_os.delete();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bit_tick === 1'b1) q_bit.push_back(k);
      if (mid_tick === 1'b1) q_mid.push_back(k);
      if (os_tick === 1'b1) q_os.push_back(k);
      div_load = (k == load_at);
      sync     = (k == sync_at);
      if (drop_at != 0 && k >= drop_at) en = 1'b0;
    end
    div_load = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (bit_tick !== 1'b0) begin n_err++; $display("FAIL reset_bit_tick got %b want 0", bit_tick); end
    n_vec++; if (mid_tick !== 1'b0) begin n_err++; $display("FAIL reset_mid_tick got %b want 0", mid_tick); end
    n_vec++; if (os_tick !== 1'b0) begin n_err++; $display("FAIL reset_os_tick got %b want 0", os_tick); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({bit_tick, mid_tick, os_tick} !== 3'b000) begin
      n_err++; $display("FAIL idle_strobes got %b want 000", {bit_tick, mid_tick, os_tick});
    end
  endtask

  task automatic test_default_timing();
    int exp[$];
    int got;
    int n_os;
    restart();
    run_cycles(900, 0, 0, 0);
    exp = '{434, 868};
    n_vec++; if (q_bit.size() != exp.size()) begin n_err++; $display("FAIL default_bit_count got %0d want %0d", q_bit.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bit.size()) ? q_bit[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL default_bit_cycle got %0d want %0d", got, exp[i]); end
    end
    exp = '{217, 651};
    n_vec++; if (q_mid.size() != exp.size()) begin n_err++; $display("FAIL default_mid_count got %0d want %0d", q_mid.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_mid.size()) ? q_mid[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL default_mid_cycle got %0d want %0d", got, exp[i]); end
    end
    n_os = 0;
    foreach (q_os[i]) if (q_os[i] <= 868) n_os++;
    n_vec++; if (n_os != 32) begin n_err++; $display("FAIL default_os_count got %0d want 32", n_os); end
    got = (q_os.size() > 0) ? q_os[0] : -1;
    n_vec++; if (got != 28) begin n_err++; $display("FAIL default_os_first got %0d want 28", got); end
    for (int i = 1; i < q_os.size(); i++) begin
      got = q_os[i] - q_os[i-1];
      n_vec++; if (got < 27 || got > 28) begin n_err++; $display("FAIL default_os_gap got %0d want 27..28", got); end
    end
  endtask

  task automatic test_div_load();
    int exp[$];
    int got;
    restart();
    div_i = 16'd868;
    run_cycles(1310, 100, 0, 0);
    exp = '{434, 1302};
    n_vec++; if (q_bit.size() != exp.size()) begin n_err++; $display("FAIL load_bit_count got %0d want %0d", q_bit.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bit.size()) ? q_bit[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL load_bit_cycle got %0d want %0d", got, exp[i]); end
    end
    exp = '{217, 868};
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_mid.size()) ? q_mid[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL load_mid_cycle got %0d want %0d", got, exp[i]); end
    end
    set_div(434);
  endtask

  task automatic test_load_at_wrap();
    int exp[$];
    int got;
    restart();
    div_i = 16'd868;
    run_cycles(1740, 433, 0, 0);
    exp = '{434, 868, 1736};
    n_vec++; if (q_bit.size() != exp.size()) begin n_err++; $display("FAIL wrapload_bit_count got %0d want %0d", q_bit.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bit.size()) ? q_bit[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL wrapload_bit_cycle got %0d want %0d", got, exp[i]); end
    end
    set_div(434);
  endtask

  task automatic test_sync();
    int exp[$];
    int got;
    int win[$];
    restart();
    run_cycles(740, 0, 300, 0);
    exp = '{734};
    n_vec++; if (q_bit.size() != exp.size()) begin n_err++; $display("FAIL sync_bit_count got %0d want %0d", q_bit.size(), exp.size()); end
    got = (q_bit.size() > 0) ? q_bit[0] : -1;
    n_vec++; if (got != 734) begin n_err++; $display("FAIL sync_bit_cycle got %0d want 734", got); end
    exp = '{217, 517};
    n_vec++; if (q_mid.size() != exp.size()) begin n_err++; $display("FAIL sync_mid_count got %0d want %0d", q_mid.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_mid.size()) ? q_mid[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL sync_mid_cycle got %0d want %0d", got, exp[i]); end
    end
    foreach (q_os[i]) if (q_os[i] >= 300 && q_os[i] <= 340) win.push_back(q_os[i]);
    n_vec++; if (win.size() != 1) begin n_err++; $display("FAIL sync_os_window_count got %0d want 1", win.size()); end
    got = (win.size() > 0) ? win[0] : -1;
    n_vec++; if (got != 328) begin n_err++; $display("FAIL sync_os_first got %0d want 328", got); end
  endtask

  task automatic test_sync_at_wrap();
    int exp[$];
    int got;
    int hit;
    restart();
    run_cycles(870, 0, 433, 0);
    exp = '{867};
    n_vec++; if (q_bit.size() != exp.size()) begin n_err++; $display("FAIL syncwrap_bit_count got %0d want %0d", q_bit.size(), exp.size()); end
    got = (q_bit.size() > 0) ? q_bit[0] : -1;
    n_vec++; if (got != 867) begin n_err++; $display("FAIL syncwrap_bit_cycle got %0d want 867", got); end
    exp = '{217, 650};
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_mid.size()) ? q_mid[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL syncwrap_mid_cycle got %0d want %0d", got, exp[i]); end
    end
    hit = 0;
    foreach (q_os[i]) if (q_os[i] == 434) hit = 1;
    n_vec++; if (hit != 0) begin n_err++; $display("FAIL syncwrap_os_434 got %0d want 0", hit); end
  endtask

  task automatic test_clamp();
    int exp[$];
    int got;
    set_div(5);
    restart();
    run_cycles(64, 0, 0, 0);
    n_vec++; if (q_os.size() != 64) begin n_err++; $display("FAIL clamp_os_count got %0d want 64", q_os.size()); end
    exp = '{16, 32, 48, 64};
    n_vec++; if (q_bit.size() != exp.size()) begin n_err++; $display("FAIL clamp_bit_count got %0d want %0d", q_bit.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bit.size()) ? q_bit[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL clamp_bit_cycle got %0d want %0d", got, exp[i]); end
    end
    exp = '{8, 24, 40, 56};
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_mid.size()) ? q_mid[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL clamp_mid_cycle got %0d want %0d", got, exp[i]); end
    end
    set_div(434);
  endtask

  task automatic test_en_drop();
    int got;
    restart();
    run_cycles(222, 0, 0, 216);
    n_vec++; if (q_mid.size() != 0) begin n_err++; $display("FAIL endrop_mid_count got %0d want 0", q_mid.size()); end
    n_vec++; if (q_bit.size() != 0) begin n_err++; $display("FAIL endrop_bit_count got %0d want 0", q_bit.size()); end
    n_vec++; if (q_os.size() != 7) begin n_err++; $display("FAIL endrop_os_count got %0d want 7", q_os.size()); end
    restart();
    run_cycles(440, 0, 0, 0);
    got = (q_mid.size() > 0) ? q_mid[0] : -1;
    n_vec++; if (got != 217) begin n_err++; $display("FAIL endrop_restart_mid got %0d want 217", got); end
    got = (q_bit.size() > 0) ? q_bit[0] : -1;
    n_vec++; if (got != 434) begin n_err++; $display("FAIL endrop_restart_bit got %0d want 434", got); end
  endtask

  task automatic test_rst_mid();
    int got;
    set_div(600);
    restart();
    run_cycles(299, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bit_tick, mid_tick, os_tick} !== 3'b000) begin
      n_err++; $display("FAIL rst_strobes got %b want 000", {bit_tick, mid_tick, os_tick});
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    restart();
    run_cycles(440, 0, 0, 0);
    got = (q_mid.size() > 0) ? q_mid[0] : -1;
    n_vec++; if (got != 217) begin n_err++; $display("FAIL rst_restart_mid got %0d want 217", got); end
    got = (q_bit.size() > 0) ? q_bit[0] : -1;
    n_vec++; if (got != 434) begin n_err++; $display("FAIL rst_restart_bit got %0d want 434", got); end
  endtask

`ifdef ZUART_BAUD_FRAC_EN
  task automatic test_frac();
    int exp[$];
    int got;
    frac_i = 4'd8;
    restart();
    run_cycles(2610, 0, 0, 0);
    exp = '{434, 868, 1303, 1737, 2172, 2606};
    n_vec++; if (q_bit.size() != exp.size()) begin n_err++; $display("FAIL frac_bit_count got %0d want %0d", q_bit.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bit.size()) ? q_bit[i] : -1;
      n_vec++; if (got != exp[i]) begin n_err++; $display("FAIL frac_bit_cycle got %0d want %0d", got, exp[i]); end
    end
    frac_i = 4'd0;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    div_i    = 16'd434;
    div_load = 1'b0;
    sync     = 1'b0;
`ifdef ZUART_BAUD_FRAC_EN
    frac_i   = 4'd0;
`endif
    test_reset();
    test_default_timing();
    test_div_load();
    test_load_at_wrap();
    test_sync();
    test_sync_at_wrap();
    test_clamp();
    test_en_drop();
    test_rst_mid();
`ifdef ZUART_BAUD_FRAC_EN
    test_frac();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
